ifft_pingpong_demux: RTL
========================

Name: ifft_pingpong_demux

Overview:
- 1-to-2 sample distributor: the inverse of the IFFT 2:1 input mux.
- Accepts a serial stream of 16-bit fixed-point IFFT samples and steers whole N-point frames alternately into two buffer banks (bank 0, bank 1).
- Each bank is exposed to its consumer as a random-access frame once full.
- Sits between the IFFT output stage and the downstream CP-insertion/transmit path. One bank fills while the other is drained.

Parameters:
- DATA_W, 16: sample width in bits (16-bit fixed point).
- N_POINTS, 16: samples per frame (IFFT size).
- ADDR_W, 4: log2(N_POINTS); bank address width.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  DATA_W  incoming IFFT sample.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  demux can accept a sample this cycle.
- bank_full_0  output  1  bank 0 holds a complete frame.
- bank_full_1  output  1  bank 1 holds a complete frame.
- rd_addr_0  input  ADDR_W  read address, bank 0.
- rd_addr_1  input  ADDR_W  read address, bank 1.
- rd_data_0  output  DATA_W  registered read data, bank 0.
- rd_data_1  output  DATA_W  registered read data, bank 1.
- rd_release_0  input  1  one-cycle pulse: consumer finished with bank 0.
- rd_release_1  input  1  one-cycle pulse: consumer finished with bank 1.
- wr_bank  output  1  bank currently being filled (debug/status).

Behaviour:
- Reset (asynchronous, rst_n low):
  - wr_bank=0, write counter=0, bank_full_0/1=0, rd_data_0/1=0.
  - in_ready goes to 1 when reset deasserts.
  - Bank memory contents are not reset.
- Input handshake:
  - in_ready = ~bank_full[wr_bank], decoded combinationally from registers only; no path from in_valid.
  - A sample is accepted when in_valid && in_ready.
  - On accept: mem[wr_bank][cnt] <= in_data; cnt increments.
- Frame completion: on the accept with cnt == N_POINTS-1:
  - cnt <= 0
  - bank_full[wr_bank] <= 1
  - wr_bank <= ~wr_bank
- Per-bank states: EMPTY (cnt 0, not target), FILLING (target, 0 < cnt), FULL. Transitions:
  - EMPTY -> FILLING on first accept.
  - FILLING -> FULL on the last accept.
  - FULL -> EMPTY on rd_release.
- Backpressure: if the next target bank is still FULL, in_ready=0 and the stream stalls with no sample loss. in_ready rises the cycle after the release is registered.
- Release handling:
  - rd_release_b clears bank_full_b on the next edge.
  - Release of a bank that is not FULL is ignored: no state change, no effect on cnt.
  - Release of the FULL target bank while in_valid=1 in the same cycle: that cycle's sample is not accepted (in_ready was 0). It is accepted the following cycle.
  - Simultaneous release of both banks is legal; both clear.
- Read port:
  - rd_data_b <= mem[b][rd_addr_b] every cycle, giving 1-cycle latency.
  - Read data is defined only while bank_full_b=1. Reading a FILLING bank returns the stored contents without side effects.
- Sample ordering: sample k of a frame (k=0 first accepted) lands at address k. No bit reversal is applied; reordering is the IFFT core's job.
- Idle gaps: in_valid may drop mid-frame for any number of cycles; cnt holds.
- Reset mid-frame discards the partial frame and any full frames; both banks return to EMPTY.

Decomposition:
- Shared ifft package/header holds:
  - IFFT_DATA_W=16, IFFT_N_POINTS=16, IFFT_ADDR_W=4
  - bank-select encoding BANK_0=1'b0, BANK_1=1'b1, shared with the IFFT input mux select.
- One natural sub-module, ifft_frame_bank: one N_POINTS x DATA_W register bank with a write port and a registered read port. It is instantiated twice.
- The top level holds the write counter, wr_bank toggle, full flags and handshake.

Test Plan:
- Reset then 16 accepted samples 0x0001..0x0010 -> bank_full_0=1 after the 16th edge, wr_bank=1, rd_addr_0=5 gives rd_data_0=0x0006 one cycle later.
- Continuous 32 samples 0x0100..0x011F -> both banks full; in_ready=0; rd_addr_1=0 gives 0x0110; rd_addr_1=15 gives 0x011F.
- Stall: both full, in_valid=1 held with 0xAAAA, pulse rd_release_0 -> in_ready=1 the next cycle; 0xAAAA is written to bank 0 addr 0 exactly once and cnt=1.
- Release of an empty bank (rd_release_1 right after reset) -> no change to bank_full_1, wr_bank or cnt.
- in_valid toggled every other cycle for 16 samples -> frame completes after 16 accepts, not 16 cycles; addresses are contiguous.
- rst_n asserted low after 7 accepts -> immediately bank_full_0/1=0, wr_bank=0, rd_data=0. The next 16 samples fill bank 0 from addr 0.

Source files
------------

// File: rtl/ifft_pingpong_demux_pkg.sv
// Shared IFFT constants, bank-select encoding and per-bank state type for the
// ping-pong output demux.
package ifft_pingpong_demux_pkg;

    localparam int unsigned IFFT_DATA_W   = 16;
    localparam int unsigned IFFT_N_POINTS = 16;
    localparam int unsigned IFFT_ADDR_W   = 4;

    // Same encoding as the IFFT input mux select.
    localparam logic BANK_0 = 1'b0;
    localparam logic BANK_1 = 1'b1;

    typedef enum logic [1:0] {
        BankEmpty,
        BankFilling,
        BankFull
    } bank_state_e;

    function automatic logic other_bank(input logic bank);
        return (bank == BANK_0) ? BANK_1 : BANK_0;
    endfunction

endpackage

// File: rtl/ifft_frame_bank.sv
// One N_POINTS x DATA_W frame buffer: single write port, registered read port.
// Storage is not reset; only the read register is.
module ifft_frame_bank #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_POINTS = 16,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [N_POINTS];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read-before-write on a colliding address; consumers only read full banks anyway.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ifft_pingpong_demux.sv
// 1-to-2 frame distributor: steers whole IFFT output frames alternately into two
// banks, each exposed as a random-access frame once full and freed by a release pulse.
module ifft_pingpong_demux
    import ifft_pingpong_demux_pkg::*;
#(
    parameter int unsigned DATA_W   = IFFT_DATA_W,
    parameter int unsigned N_POINTS = IFFT_N_POINTS,
    parameter int unsigned ADDR_W   = IFFT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bank_full_0,
    output logic              bank_full_1,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic [DATA_W-1:0] rd_data_0,
    output logic [DATA_W-1:0] rd_data_1,
    input  logic              rd_release_0,
    input  logic              rd_release_1,
    output logic              wr_bank
);

    logic              wr_bank_q, wr_bank_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    bank_state_e       state_q [2];
    bank_state_e       state_d [2];

    logic       accept;
    logic       last;
    logic [1:0] release_req;
    logic       wr_en_0, wr_en_1;

    assign bank_full_0 = (state_q[0] == BankFull);
    assign bank_full_1 = (state_q[1] == BankFull);
    assign wr_bank     = wr_bank_q;

    // Registers only: no combinational path from in_valid to in_ready.
    assign in_ready = (wr_bank_q == BANK_0) ? !bank_full_0 : !bank_full_1;

    assign accept      = in_valid && in_ready;
    assign last        = (cnt_q == ADDR_W'(N_POINTS - 1));
    assign release_req = {rd_release_1, rd_release_0};
    assign wr_en_0     = accept && (wr_bank_q == BANK_0);
    assign wr_en_1     = accept && (wr_bank_q == BANK_1);

    always_comb begin
        wr_bank_d = wr_bank_q;
        cnt_d     = cnt_q;
        if (accept) begin
            if (last) begin
                cnt_d     = '0;
                wr_bank_d = other_bank(wr_bank_q);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // A release only acts on a FULL bank; a FULL bank is never the accepting target.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            unique case (state_q[b])
                BankEmpty: begin
                    if (accept && (wr_bank_q == 1'(b))) begin
                        state_d[b] = last ? BankFull : BankFilling;
                    end
                end
                BankFilling: begin
                    if (accept && (wr_bank_q == 1'(b)) && last) begin
                        state_d[b] = BankFull;
                    end
                end
                BankFull: begin
                    if (release_req[b]) begin
                        state_d[b] = BankEmpty;
                    end
                end
                default: state_d[b] = BankEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank_q <= BANK_0;
            cnt_q     <= '0;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= BankEmpty;
            end
        end else begin
            wr_bank_q <= wr_bank_d;
            cnt_q     <= cnt_d;
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
            end
        end
    end

    ifft_frame_bank #(
        .DATA_W   (DATA_W),
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W)
    ) u_bank_0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_0),
        .wr_addr (cnt_q),
        .wr_data (in_data),
        .rd_addr (rd_addr_0),
        .rd_data (rd_data_0)
    );

    ifft_frame_bank #(
        .DATA_W   (DATA_W),
        .N_POINTS (N_POINTS),
        .ADDR_W   (ADDR_W)
    ) u_bank_1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en_1),
        .wr_addr (cnt_q),
        .wr_data (in_data),
        .rd_addr (rd_addr_1),
        .rd_data (rd_data_1)
    );

endmodule
